match_controller: RTL

//  Sequences a Pong match around the collision checker. Consumes the checker's per-clock

---
 rtl/pong_pkg.sv | 28 ++
 rtl/event_qualifier.sv | 43 ++++
 rtl/match_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: bounce codes from the collision checker, winner codes and the
// match FSM state encoding. Also used by the ball FSM and the score display.
package pong_pkg;

   // Bounce codes; goal preempts the others upstream, so only one code is present per clock.
   localparam logic [1:0] BNC_NONE   = 2'b00;
   localparam logic [1:0] BNC_PADDLE = 2'b01;
   localparam logic [1:0] BNC_WALL   = 2'b10;
   localparam logic [1:0] BNC_GOAL   = 2'b11;

   localparam logic [1:0] WINNER_NONE = 2'b00;
   localparam logic [1:0] WINNER_P1   = 2'b01;
   localparam logic [1:0] WINNER_P2   = 2'b10;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StServe    = 3'd1,
      StRally    = 3'd2,
      StPoint    = 3'd3,
      StGameOver = 3'd4
   } state_e;

   // 4-bit score increment that sticks at 15.
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hf) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/event_qualifier.sv
// Turns the per-clock bounce code into at most one contact event per distinct code.
// Ports:
//   clock, reset_n     system clock, asynchronous active-low reset
//   frame_tick_i       one-cycle frame strobe; events are only accepted on it
//   bounce_i           raw bounce code from the collision checker
//   goal_side_i        goal edge, meaningful with a goal code
//   code_o, side_o     registered code and goal side
//   accept_o           high on a frame tick whose code is non-zero and differs from the last frame
module event_qualifier
   import pong_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       frame_tick_i,
   input  logic [1:0] bounce_i,
   input  logic       goal_side_i,
   output logic [1:0] code_o,
   output logic       side_o,
   output logic       accept_o
);

   logic [1:0] code_q;
   logic [1:0] prev_q;
   logic       side_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         code_q <= BNC_NONE;
         prev_q <= BNC_NONE;
         side_q <= 1'b0;
      end else begin
         code_q <= bounce_i;
         side_q <= goal_side_i;
         // Tracking per frame (not per clock) makes a code held over many frames one event.
         if (frame_tick_i) prev_q <= code_q;
      end
   end

   assign code_o   = code_q;
   assign side_o   = side_q;
   assign accept_o = frame_tick_i && (code_q != BNC_NONE) && (code_q != prev_q);

endmodule

// File: rtl/match_controller.sv
// Pong match sequencer: serve delay, rally event handling, scoring and game-over timing.
// Ports:
//   clock, reset_n            system clock, asynchronous active-low reset
//   frame_tick, start         frame strobe, start button level (synchronised upstream)
//   bounce, goal_side         collision checker code and goal edge
//   ball_reset, ball_launch   ball FSM command pulses; serve_dir gives launch direction
//   reflect_x, reflect_y      velocity negate pulses for paddle and wall hits
//   score_p1, score_p2        scores; winner is the match result; state_dbg is the FSM state
module match_controller
   import pong_pkg::*;
#(
   parameter int unsigned WIN_SCORE    = 11,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned OVER_FRAMES  = 180
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [1:0] bounce,
   input  logic       goal_side,
   output logic       ball_reset,
   output logic       ball_launch,
   output logic       serve_dir,
   output logic       reflect_x,
   output logic       reflect_y,
   output logic [3:0] score_p1,
   output logic [3:0] score_p2,
   output logic [1:0] winner,
   output logic [2:0] state_dbg
);

   localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
   localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);
   localparam logic [3:0] WIN4       = 4'(WIN_SCORE);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] score_p1_q, score_p1_d, score_p2_q, score_p2_d;
   logic [1:0] winner_q, winner_d;
   logic       serve_dir_q, serve_dir_d;
   logic       ball_reset_q, ball_reset_d, ball_launch_q, ball_launch_d;
   logic       reflect_x_q, reflect_x_d, reflect_y_q, reflect_y_d;
   logic       start_q, start_qq;
   logic [1:0] code;
   logic       side, accept, start_rise, scorer_p1;

   event_qualifier u_event_qualifier (
      .clock        (clock),
      .reset_n      (reset_n),
      .frame_tick_i (frame_tick),
      .bounce_i     (bounce),
      .goal_side_i  (goal_side),
      .code_o       (code),
      .side_o       (side),
      .accept_o     (accept)
   );

   // start is registered once, like bounce, so both paths share the same command latency.
   assign start_rise = start_q && !start_qq;
   // The loser serves, so serve_dir was set away from the scorer's launch side on the goal.
   assign scorer_p1  = !serve_dir_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      score_p1_d    = score_p1_q;
      score_p2_d    = score_p2_q;
      winner_d      = winner_q;
      serve_dir_d   = serve_dir_q;
      ball_reset_d  = 1'b0;
      ball_launch_d = 1'b0;
      reflect_x_d   = 1'b0;
      reflect_y_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_rise) begin
               score_p1_d   = 4'd0;
               score_p2_d   = 4'd0;
               winner_d     = WINNER_NONE;
               ball_reset_d = 1'b1;
               state_d      = StServe;
            end
         end
         StServe: begin
            if (frame_tick) begin
               if (cnt_q == SERVE_LAST) begin
                  ball_launch_d = 1'b1;
                  state_d       = StRally;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         StRally: begin
            if (accept) begin
               case (code)
                  BNC_PADDLE: reflect_x_d = 1'b1;
                  BNC_WALL:   reflect_y_d = 1'b1;
                  BNC_GOAL: begin
                     if (side) score_p1_d = sat_inc(score_p1_q);
                     else      score_p2_d = sat_inc(score_p2_q);
                     serve_dir_d = !side;
                     state_d     = StPoint;
                  end
                  default: ;
               endcase
            end
         end
         StPoint: begin
            ball_reset_d = 1'b1;
            if ((scorer_p1 ? score_p1_q : score_p2_q) == WIN4) begin
               winner_d = scorer_p1 ? WINNER_P1 : WINNER_P2;
               state_d  = StGameOver;
            end else begin
               state_d = StServe;
            end
         end
         StGameOver: begin
            if (frame_tick) begin
               if (cnt_q == OVER_LAST) state_d = StIdle;
               else                    cnt_d   = cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      // A tick on the entry cycle is tick 0: the counter restarts on every transition.
      if (state_d != state_q) cnt_d = 8'd0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         cnt_q         <= 8'd0;
         score_p1_q    <= 4'd0;
         score_p2_q    <= 4'd0;
         winner_q      <= WINNER_NONE;
         serve_dir_q   <= 1'b0;
         ball_reset_q  <= 1'b0;
         ball_launch_q <= 1'b0;
         reflect_x_q   <= 1'b0;
         reflect_y_q   <= 1'b0;
         start_q       <= 1'b0;
         start_qq      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         score_p1_q    <= score_p1_d;
         score_p2_q    <= score_p2_d;
         winner_q      <= winner_d;
         serve_dir_q   <= serve_dir_d;
         ball_reset_q  <= ball_reset_d;
         ball_launch_q <= ball_launch_d;
         reflect_x_q   <= reflect_x_d;
         reflect_y_q   <= reflect_y_d;
         start_q       <= start;
         start_qq      <= start_q;
      end
   end

   assign ball_reset  = ball_reset_q;
   assign ball_launch = ball_launch_q;
   assign serve_dir   = serve_dir_q;
   assign reflect_x   = reflect_x_q;
   assign reflect_y   = reflect_y_q;
   assign score_p1    = score_p1_q;
   assign score_p2    = score_p2_q;
   assign winner      = winner_q;
   assign state_dbg   = state_q;

endmodule
